// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring unsigned divider with valid/ready handshake
// Optional: ITER_DIVIDER_FASTZERO_EN completes divide-by-zero straight from IDLE.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
  always_comb begin
    trial = {rem, dvd[WIDTH-1]};
    diff  = trial - {1'b0, dsr};
    take  = (trial >= {1'b0, dsr});
  end

  assign in_ready    = rst_n && (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dsr   <= '0;
      quo   <= '0;
      rem   <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd <= dividend;
            dsr <= divisor;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
            dbz <= (divisor == '0);
`ifdef ITER_DIVIDER_FASTZERO_EN
            if (divisor == '0) begin
              quo   <= '1;
              rem   <= dividend;
              state <= DONE;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          if (take) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider against an arithmetic model
module tb_iter_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests;
  int fails;

  iter_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, measure latency, optionally stall, then complete the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    int           exp_lat;
    logic [63:0]  recon;
    eq = (b == 0) ? '1 : a / b;
    er = (b == 0) ? a : a % b;
    ez = (b == 0);
`ifdef ITER_DIVIDER_FASTZERO_EN
    exp_lat = (b == 0) ? 0 : W;
`else
    exp_lat = W;
`endif
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    if (!out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("quotient", 64'(quotient), 64'(eq));
    chk("remainder", 64'(remainder), 64'(er));
    chk("div_by_zero", 64'(div_by_zero), 64'(ez));
    if (b != 0) begin
      recon = 64'(quotient) * 64'(b) + 64'(remainder);
      chk("invariant_recon", recon, 64'(a));
      chk("invariant_rem_lt", 64'(remainder < b), 64'd1);
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = 32'd7;
      divisor  = 32'd7;
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_quotient", 64'(quotient), 64'(eq));
      chk("stall_remainder", 64'(remainder), 64'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_quotient_held", 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'h1234_5678, 32'h1234_5679, 0);
    run_op(32'd5, 32'd0, 0);
    run_op(32'd1000, 32'd10, 10);

    // Reset in the middle of 100/7.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_in_ready", 64'(in_ready), 64'd1);
    run_op(32'd9, 32'd3, 0);

    for (int k = 0; k < 20; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (k == 7) rb = '0;
      run_op(ra, rb, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
